reg_word_assembler: RTL and testbench
=====================================

# reg_word_assembler

Sits directly downstream of the bus interface stage. Consumes its byte-wide read/write strobes and turns them into 16-bit register-level transactions for the register and VRAM logic.
- Writes: an even-byte write is held, and the following odd-byte write commits the full word.
- Reads: an even-byte read fetches a word snapshot through a request/acknowledge handshake with the register block. Bytes are then returned from that snapshot to the bus data driver.
- Writes that arrive while a read is outstanding are buffered, and overruns are flagged.

## Interface
Parameters:
- RD_TIMEOUT, default 15: cycles to wait for `reg_rd_ack_i` before forcing the snapshot to 16'hFFFF. Range 1-255.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n_i  in  1  synchronous, active-low reset, sampled on rising `clk`.
- write_strobe_i  in  1  one-cycle byte write strobe from the bus interface.
- read_strobe_i  in  1  one-cycle byte read strobe from the bus interface.
- reg_num_i  in  4  register number, valid with the strobes.
- bytesel_i  in  1  0 = even (high) byte, 1 = odd (low) byte.
- bytedata_i  in  8  byte written, valid with `write_strobe_i`.
- reg_wr_o  out  1  one-cycle 16-bit register write strobe.
- reg_wr_num_o  out  4  register number for `reg_wr_o`.
- reg_wr_data_o  out  16  word for `reg_wr_o`.
- reg_rd_req_o  out  1  read request, held high until acknowledged or timed out.
- reg_rd_num_o  out  4  register number for `reg_rd_req_o`.
- reg_rd_data_i  in  16  read word, valid when `reg_rd_ack_i` is high.
- reg_rd_ack_i  in  1  read acknowledge.
- bus_data_o  out  8  registered read byte presented to the bus data driver.
- overrun_o  out  1  sticky error flag; cleared only by reset.

## Operation
- Reset (`reset_n_i` = 0 at a clock edge) sets all of the following; it takes effect even mid-handshake and discards any pending write:
  - state = IDLE
  - `reg_wr_o` = 0, `reg_wr_num_o` = 0, `reg_wr_data_o` = 0
  - `reg_rd_req_o` = 0, `reg_rd_num_o` = 0
  - `bus_data_o` = 0, `overrun_o` = 0
  - hold byte = 0, snapshot = 0, byte-select latch = 0, timeout counter = 0, pending slot empty
- Hold byte:
  - One shared hold byte, not per-register.
  - An even write stores `bytedata_i` in it; nothing is issued.
  - An odd write to register R issues word {hold, `bytedata_i`} to R, whichever register the hold byte was written for. The last even byte wins.
  - The hold byte is not cleared after it is used.
- State machine, IDLE / RD_WAIT / FLUSH:
  - IDLE, odd write: issue it (see Timing).
  - IDLE, even read: latch `reg_num_i` into `reg_rd_num_o`, assert `reg_rd_req_o`, load the timeout counter with RD_TIMEOUT, go to RD_WAIT.
  - IDLE, odd read: no request; byte-select latch = 1.
  - RD_WAIT, `reg_rd_ack_i` = 1: snapshot = `reg_rd_data_i`, drop the request, go to FLUSH if a write is pending, otherwise IDLE.
  - RD_WAIT, counter reaches 0 without ack: snapshot = 16'hFFFF, drop the request, then the same next-state choice as on ack.
  - RD_WAIT, odd write: its word is computed immediately from the current hold byte and stored in the single pending slot.
  - RD_WAIT, even write: updates the hold byte normally.
  - RD_WAIT, odd write while the slot is already full: write is dropped; set `overrun_o`.
  - RD_WAIT, any read strobe: read is ignored; set `overrun_o`.
  - FLUSH: issue the pending write, empty the slot, go to IDLE.
  - FLUSH, read strobe: handled exactly as in IDLE.
  - FLUSH, odd write: stored as pending; it issues in the cycle after.
- Read byte selection: `bus_data_o` = snapshot[15:8] when the byte-select latch is 0, and snapshot[7:0] when it is 1.
  - An even read sets the latch to 0. An odd read accepted in IDLE or FLUSH sets it to 1.
- Strobes are mutually exclusive. If both are asserted, the write is handled and the read is ignored with no overrun.

## Timing
- Odd write strobe at cycle N (IDLE) → `reg_wr_o` = 1 for cycle N+1 only, with num/data valid in that same cycle.
- Even read strobe at cycle N → `reg_rd_req_o` = 1 from cycle N+1.
- Ack sampled high at cycle M → at M+1: `reg_rd_req_o` = 0, snapshot and `bus_data_o` updated.
- Pending write: the FLUSH state is entered at M+1, and `reg_wr_o` is high at M+2.
- Timeout: with no ack, the request is high for exactly RD_TIMEOUT cycles (N+1 … N+RD_TIMEOUT). At N+RD_TIMEOUT+1, `reg_rd_req_o` = 0 and `bus_data_o` = 8'hFF.
- Ack and timeout in the same cycle: ack wins and its data is captured.
- Odd read strobe at N → `bus_data_o` = snapshot[7:0] at N+1.
- `reg_rd_ack_i` outside RD_WAIT is ignored.

## Test plan
- Hold-byte write: even write 0x12 to reg 3, then odd write 0x34 to reg 3 → a single `reg_wr_o` pulse with num 3 and data 0x1234. No pulse after the even write.
- Read path: even read of reg 5, ack 2 cycles later with data 0xBEEF → `bus_data_o` = 0xBE. Then odd read → `bus_data_o` = 0xEF, and `reg_rd_req_o` is not reasserted.
- Timeout: RD_TIMEOUT = 4, even read, no ack → request high for exactly 4 cycles, then `bus_data_o` = 0xFF, state returns to IDLE.
- Write during read: even write 0xAA, even read, then odd write 0x55 to reg 2 before ack; ack at cycle M → `reg_wr_o` with data 0xAA55 to reg 2 at M+2, `overrun_o` = 0.
- Overrun: two odd writes during RD_WAIT, then a read strobe → only the first write issues, `overrun_o` = 1 and stays 1 until `reset_n_i` = 0.
- Reset mid-RD_WAIT with a pending write → next cycle all outputs are 0, no `reg_wr_o`, and a later ack is ignored.

Source files
------------

// File: rtl/reg_word_assembler.sv
// rtl/reg_word_assembler.sv - byte strobes to 16-bit register write/read transactions
module reg_word_assembler #(
   parameter int RD_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        write_strobe_i,
   input  logic        read_strobe_i,
   input  logic [3:0]  reg_num_i,
   input  logic        bytesel_i,
   input  logic [7:0]  bytedata_i,
   output logic        reg_wr_o,
   output logic [3:0]  reg_wr_num_o,
   output logic [15:0] reg_wr_data_o,
   output logic        reg_rd_req_o,
   output logic [3:0]  reg_rd_num_o,
   input  logic [15:0] reg_rd_data_i,
   input  logic        reg_rd_ack_i,
   output logic [7:0]  bus_data_o,
   output logic        overrun_o
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, FLUSH} state_t;

   state_t      state_q, state_d;
   logic        reg_wr_q, reg_wr_d;
   logic [3:0]  wr_num_q, wr_num_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        rd_req_q, rd_req_d;
   logic [3:0]  rd_num_q, rd_num_d;
   logic [7:0]  hold_q, hold_d;
   logic [15:0] snap_q, snap_d;
   logic        sel_q, sel_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        pend_v_q, pend_v_d;
   logic [3:0]  pend_num_q, pend_num_d;
   logic [15:0] pend_data_q, pend_data_d;
   logic        ovr_q, ovr_d;

   logic        odd_wr, even_wr, rd_acc;
   logic [15:0] word;

   assign odd_wr  = write_strobe_i & bytesel_i;
   assign even_wr = write_strobe_i & ~bytesel_i;
   // A simultaneous write takes priority; the read is silently dropped.
   assign rd_acc  = read_strobe_i & ~write_strobe_i;
   assign word    = {hold_q, bytedata_i};

   always_comb begin
      state_d     = state_q;
      reg_wr_d    = 1'b0;
      wr_num_d    = wr_num_q;
      wr_data_d   = wr_data_q;
      rd_req_d    = rd_req_q;
      rd_num_d    = rd_num_q;
      hold_d      = hold_q;
      snap_d      = snap_q;
      sel_d       = sel_q;
      tmo_d       = tmo_q;
      pend_v_d    = pend_v_q;
      pend_num_d  = pend_num_q;
      pend_data_d = pend_data_q;
      ovr_d       = ovr_q;

      if (even_wr) hold_d = bytedata_i;

      case (state_q)
         IDLE: begin
            if (odd_wr) begin
               reg_wr_d  = 1'b1;
               wr_num_d  = reg_num_i;
               wr_data_d = word;
            end else if (rd_acc) begin
               if (!bytesel_i) begin
                  rd_num_d = reg_num_i;
                  rd_req_d = 1'b1;
                  tmo_d    = 8'(RD_TIMEOUT);
                  sel_d    = 1'b0;
                  state_d  = RD_WAIT;
               end else begin
                  sel_d = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            if (odd_wr) begin
               if (pend_v_q) begin
                  ovr_d = 1'b1;
               end else begin
                  pend_v_d    = 1'b1;
                  pend_num_d  = reg_num_i;
                  pend_data_d = word;
               end
            end
            if (rd_acc) ovr_d = 1'b1;
            // Ack beats a simultaneous timeout; the counter expires on its last request cycle.
            if (reg_rd_ack_i || tmo_q <= 8'd1) begin
               snap_d   = reg_rd_ack_i ? reg_rd_data_i : 16'hFFFF;
               rd_req_d = 1'b0;
               state_d  = pend_v_d ? FLUSH : IDLE;
            end else begin
               tmo_d = tmo_q - 8'd1;
            end
         end
         FLUSH: begin
            reg_wr_d  = 1'b1;
            wr_num_d  = pend_num_q;
            wr_data_d = pend_data_q;
            pend_v_d  = 1'b0;
            state_d   = IDLE;
            if (odd_wr) begin
               pend_v_d    = 1'b1;
               pend_num_d  = reg_num_i;
               pend_data_d = word;
               state_d     = FLUSH;
            end else if (rd_acc) begin
               if (!bytesel_i) begin
                  rd_num_d = reg_num_i;
                  rd_req_d = 1'b1;
                  tmo_d    = 8'(RD_TIMEOUT);
                  sel_d    = 1'b0;
                  state_d  = RD_WAIT;
               end else begin
                  sel_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         reg_wr_q    <= 1'b0;
         wr_num_q    <= '0;
         wr_data_q   <= '0;
         rd_req_q    <= 1'b0;
         rd_num_q    <= '0;
         hold_q      <= '0;
         snap_q      <= '0;
         sel_q       <= 1'b0;
         tmo_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_num_q  <= '0;
         pend_data_q <= '0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_wr_q    <= reg_wr_d;
         wr_num_q    <= wr_num_d;
         wr_data_q   <= wr_data_d;
         rd_req_q    <= rd_req_d;
         rd_num_q    <= rd_num_d;
         hold_q      <= hold_d;
         snap_q      <= snap_d;
         sel_q       <= sel_d;
         tmo_q       <= tmo_d;
         pend_v_q    <= pend_v_d;
         pend_num_q  <= pend_num_d;
         pend_data_q <= pend_data_d;
         ovr_q       <= ovr_d;
      end
   end

   assign reg_wr_o      = reg_wr_q;
   assign reg_wr_num_o  = wr_num_q;
   assign reg_wr_data_o = wr_data_q;
   assign reg_rd_req_o  = rd_req_q;
   assign reg_rd_num_o  = rd_num_q;
   assign bus_data_o    = sel_q ? snap_q[7:0] : snap_q[15:8];
   assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_reg_word_assembler.sv
// tb/tb_reg_word_assembler.sv - scoreboard bench for reg_word_assembler
module tb_reg_word_assembler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        write_strobe = 1'b0;
   logic        read_strobe = 1'b0;
   logic [3:0]  reg_num = '0;
   logic        bytesel = 1'b0;
   logic [7:0]  bytedata = '0;
   logic        reg_wr;
   logic [3:0]  reg_wr_num;
   logic [15:0] reg_wr_data;
   logic        reg_rd_req;
   logic [3:0]  reg_rd_num;
   logic [15:0] reg_rd_data = '0;
   logic        reg_rd_ack = 1'b0;
   logic [7:0]  bus_data;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q[$];

   always #5 clk = ~clk;

   reg_word_assembler #(.RD_TIMEOUT(4)) dut (
      .clk(clk), .reset_n_i(reset_n),
      .write_strobe_i(write_strobe), .read_strobe_i(read_strobe),
      .reg_num_i(reg_num), .bytesel_i(bytesel), .bytedata_i(bytedata),
      .reg_wr_o(reg_wr), .reg_wr_num_o(reg_wr_num), .reg_wr_data_o(reg_wr_data),
      .reg_rd_req_o(reg_rd_req), .reg_rd_num_o(reg_rd_num),
      .reg_rd_data_i(reg_rd_data), .reg_rd_ack_i(reg_rd_ack),
      .bus_data_o(bus_data), .overrun_o(overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] n, input logic s, input logic [7:0] d);
      write_strobe = 1'b1; reg_num = n; bytesel = s; bytedata = d;
      cyc();
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [3:0] n, input logic s);
      read_strobe = 1'b1; reg_num = n; bytesel = s;
      cyc();
      read_strobe = 1'b0;
   endtask

   task automatic ack(input logic [15:0] d);
      reg_rd_ack = 1'b1; reg_rd_data = d;
      cyc();
      reg_rd_ack = 1'b0;
   endtask

   // Monitor: every write pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (reset_n && reg_wr) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", {12'h0, reg_wr_num, reg_wr_data}, 32'hDEAD);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("wr_word", {12'h0, reg_wr_num, reg_wr_data}, {12'h0, e});
         end
      end
   end

   initial begin
      int cnt;
      repeat (2) cyc();
      chk("rst_wr", reg_wr, 0);
      chk("rst_wr_num", reg_wr_num, 0);
      chk("rst_wr_data", reg_wr_data, 0);
      chk("rst_req", reg_rd_req, 0);
      chk("rst_rd_num", reg_rd_num, 0);
      chk("rst_bus", bus_data, 0);
      chk("rst_ovr", overrun, 0);
      reset_n = 1'b1;
      cyc();

      // Hold-byte write
      wr(4'd3, 1'b0, 8'h12);
      chk("even_no_wr", reg_wr, 0);
      exp_q.push_back({4'd3, 16'h1234});
      wr(4'd3, 1'b1, 8'h34);
      chk("odd_wr_pulse", reg_wr, 1);
      cyc();
      chk("wr_one_cycle", reg_wr, 0);

      // Read path
      rd(4'd5, 1'b0);
      chk("req_high", reg_rd_req, 1);
      chk("rd_num", reg_rd_num, 5);
      cyc();
      ack(16'hBEEF);
      chk("req_drop", reg_rd_req, 0);
      chk("bus_hi", bus_data, 8'hBE);
      rd(4'd5, 1'b1);
      chk("bus_lo", bus_data, 8'hEF);
      chk("odd_rd_no_req", reg_rd_req, 0);

      // Timeout
      rd(4'd7, 1'b0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!reg_rd_req) break;
         cnt++;
         cyc();
      end
      chk("tmo_len", cnt, 4);
      chk("tmo_bus", bus_data, 8'hFF);
      exp_q.push_back({4'd1, 16'h1277});
      wr(4'd1, 1'b1, 8'h77);
      chk("idle_after_tmo", reg_wr, 1);

      // Write during read
      wr(4'd9, 1'b0, 8'hAA);
      rd(4'd2, 1'b0);
      exp_q.push_back({4'd2, 16'hAA55});
      wr(4'd2, 1'b1, 8'h55);
      chk("no_wr_in_wait", reg_wr, 0);
      cyc();
      ack(16'h1111);
      chk("flush_m1", reg_wr, 0);
      cyc();
      chk("flush_m2", reg_wr, 1);
      chk("flush_data", reg_wr_data, 16'hAA55);
      chk("no_ovr", overrun, 0);
      chk("bus_1111", bus_data, 8'h11);

      // Overrun
      rd(4'd4, 1'b0);
      exp_q.push_back({4'd4, 16'hAA01});
      wr(4'd4, 1'b1, 8'h01);
      wr(4'd4, 1'b1, 8'h02);
      chk("ovr_drop", overrun, 1);
      rd(4'd4, 1'b1);
      ack(16'h2222);
      repeat (3) cyc();
      chk("ovr_sticky", overrun, 1);
      chk("ignored_rd_sel", bus_data, 8'h22);

      // Reset mid-RD_WAIT with pending write
      rd(4'd6, 1'b0);
      wr(4'd6, 1'b1, 8'h03);
      reset_n = 1'b0;
      cyc();
      chk("rst2_wr", reg_wr, 0);
      chk("rst2_req", reg_rd_req, 0);
      chk("rst2_wr_data", reg_wr_data, 0);
      chk("rst2_bus", bus_data, 0);
      chk("rst2_ovr", overrun, 0);
      reset_n = 1'b1;
      ack(16'h9999);
      chk("ack_ignored_bus", bus_data, 0);
      repeat (2) cyc();
      chk("no_flush_after_rst", reg_wr, 0);
      exp_q.push_back({4'd0, 16'h0056});
      wr(4'd0, 1'b1, 8'h56);

      repeat (4) cyc();
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
